multi_issue_instruction_queue: RTL and testbench

Parametrised successor to the single-issue instruction queue: a circular buffer between the PC/fetch stage and decode/dispatch. Accepts a fetch block of up to NUM_FIFO_INPUT_ENTRY instructions per cycle. Presents up to ISSUE_WIDTH in-order entries per cycle, each with a rotating Tomasulo tag and a speculation flag. Decode and RS routing stay downstream.

---
 rtl/multi_issue_instruction_queue_pkg.sv | 24 ++
 rtl/multi_issue_instruction_queue_if.sv | 51 +++++
 rtl/multi_issue_instruction_queue_tag_rotator.sv | 30 +++
 rtl/multi_issue_instruction_queue.sv | 135 +++++++++++++
 tb/tb_multi_issue_instruction_queue.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/multi_issue_instruction_queue_pkg.sv
// multi_issue_instruction_queue_pkg: shared opcode constants, control-flow test and entry layout.
// Data, address and history widths of the stored entry are fixed here; the top's width parameters must match.
package multi_issue_iq_pkg;

    localparam int IQ_BW_DATA = 32;
    localparam int IQ_BW_ADDRESS = 32;
    localparam int IQ_NUM_GLOBAL_HISTORY = 4;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_JAL = 7'b1101111;

    function automatic logic is_control_flow(input logic [IQ_BW_DATA-1:0] instr);
        return instr[6:0] == OPC_BRANCH || instr[6:0] == OPC_JALR || instr[6:0] == OPC_JAL;
    endfunction

    typedef struct packed {
        logic [IQ_NUM_GLOBAL_HISTORY-1:0] global_history;
        logic [IQ_BW_DATA-1:0] instruction;
        logic [IQ_BW_ADDRESS-1:0] pc_next;
        logic [IQ_BW_ADDRESS-1:0] pc;
    } iq_entry_t;

endpackage

// File: rtl/multi_issue_instruction_queue_if.sv
// multi_issue_instruction_queue_if: fetch-block input, branch resolution and multi-lane issue bus.
// slave is the queue's view, master is the fetch/dispatch side.
interface multi_issue_instruction_queue_if #(
    parameter int BW_PROCESSOR_BLOCK = 64,
    parameter int BW_PROCESSOR_DATA = 32,
    parameter int BW_ADDRESS = 32,
    parameter int NUM_GLOBAL_HISTORY = 4,
    parameter int IQ_DEPTH = 8,
    parameter int ISSUE_WIDTH = 2,
    parameter int BW_TAG = 4
);
    localparam int NUM_FIFO_INPUT_ENTRY = BW_PROCESSOR_BLOCK / BW_PROCESSOR_DATA;
    localparam int BW_PC_MOD = $clog2(NUM_FIFO_INPUT_ENTRY) + ((NUM_FIFO_INPUT_ENTRY <= 1) ? 1 : 0);
    localparam int BW_CNT = $clog2(IQ_DEPTH + 1);

    logic i_pc_valid;
    logic i_pc_ready;
    logic [BW_PROCESSOR_BLOCK-1:0] i_pc_instruction_flatten;
    logic [BW_ADDRESS-1:0] i_pc_pc;
    logic [BW_PC_MOD-1:0] i_pc_pc_upperbound;
    logic [NUM_GLOBAL_HISTORY-1:0] i_pc_global_history;
    logic [BW_PROCESSOR_BLOCK-1:0] i_pc_pc_next_flatten;
    logic i_branch_valid;
    logic i_branch_flush;
    logic [ISSUE_WIDTH-1:0] o_issue_valid;
    logic [ISSUE_WIDTH-1:0] i_issue_ready;
    logic [ISSUE_WIDTH*BW_PROCESSOR_DATA-1:0] o_issue_instruction_flatten;
    logic [ISSUE_WIDTH*BW_ADDRESS-1:0] o_issue_pc_flatten;
    logic [ISSUE_WIDTH*BW_ADDRESS-1:0] o_issue_pc_next_flatten;
    logic [ISSUE_WIDTH*NUM_GLOBAL_HISTORY-1:0] o_issue_global_history_flatten;
    logic [ISSUE_WIDTH*BW_TAG-1:0] o_issue_tag_flatten;
    logic [ISSUE_WIDTH-1:0] o_issue_speculation;
    logic [BW_CNT-1:0] o_count;

    modport slave (
        input i_pc_valid, i_pc_instruction_flatten, i_pc_pc, i_pc_pc_upperbound,
        input i_pc_global_history, i_pc_pc_next_flatten, i_branch_valid, i_branch_flush, i_issue_ready,
        output i_pc_ready, o_issue_valid, o_issue_instruction_flatten, o_issue_pc_flatten,
        output o_issue_pc_next_flatten, o_issue_global_history_flatten, o_issue_tag_flatten,
        output o_issue_speculation, o_count
    );

    modport master (
        output i_pc_valid, i_pc_instruction_flatten, i_pc_pc, i_pc_pc_upperbound,
        output i_pc_global_history, i_pc_pc_next_flatten, i_branch_valid, i_branch_flush, i_issue_ready,
        input i_pc_ready, o_issue_valid, o_issue_instruction_flatten, o_issue_pc_flatten,
        input o_issue_pc_next_flatten, o_issue_global_history_flatten, o_issue_tag_flatten,
        input o_issue_speculation, o_count
    );

endinterface

// File: rtl/multi_issue_instruction_queue_tag_rotator.sv
// iq_tag_rotator: per-lane Tomasulo tags and the post-issue tag, cycling 1..2^BW_TAG-1 and never producing 0.
module iq_tag_rotator #(
    parameter int ISSUE_WIDTH = 2,
    parameter int BW_TAG = 4,
    parameter int BW_CNT = 4
) (
    input  logic [BW_TAG-1:0] tag_i,
    input  logic [BW_CNT-1:0] nout_i,
    output logic [ISSUE_WIDTH*BW_TAG-1:0] lane_tag_o,
    output logic [BW_TAG-1:0] tag_next_o
);

    function automatic logic [BW_TAG-1:0] next_tag(input logic [BW_TAG-1:0] t);
        return (&t) ? BW_TAG'(1) : t + BW_TAG'(1);
    endfunction

    logic [BW_TAG-1:0] t;

    always_comb begin
        t = tag_i;
        lane_tag_o = '0;
        tag_next_o = tag_i;
        for (int k = 0; k <= ISSUE_WIDTH; k++) begin
            if (k < ISSUE_WIDTH) lane_tag_o[k*BW_TAG +: BW_TAG] = t;
            if (nout_i == BW_CNT'(k)) tag_next_o = t;
            t = next_tag(t);
        end
    end

endmodule

// File: rtl/multi_issue_instruction_queue.sv
// multi_issue_instruction_queue: circular buffer taking fetch blocks and issuing up to ISSUE_WIDTH in-order entries.
// Optional MULTI_ISSUE_IQ_SPECULATION_EN adds speculation tracking; otherwise o_issue_speculation is tied 0.
module multi_issue_instruction_queue
    import multi_issue_iq_pkg::*;
#(
    parameter int BW_PROCESSOR_BLOCK = 64,
    parameter int BW_PROCESSOR_DATA = IQ_BW_DATA,
    parameter int BW_ADDRESS = IQ_BW_ADDRESS,
    parameter int NUM_GLOBAL_HISTORY = IQ_NUM_GLOBAL_HISTORY,
    parameter int IQ_DEPTH = 8,
    parameter int ISSUE_WIDTH = 2,
    parameter int BW_TAG = 4
) (
    input logic clk,
    input logic rst,
    multi_issue_instruction_queue_if.slave iq_if
);

    localparam int NUM_FIFO_INPUT_ENTRY = BW_PROCESSOR_BLOCK / BW_PROCESSOR_DATA;
    localparam int BW_PC_MOD = $clog2(NUM_FIFO_INPUT_ENTRY) + ((NUM_FIFO_INPUT_ENTRY <= 1) ? 1 : 0);
    localparam int BW_PTR = $clog2(IQ_DEPTH);
    localparam int BW_CNT = $clog2(IQ_DEPTH + 1);

    iq_entry_t mem_q [IQ_DEPTH];
    iq_entry_t slot [NUM_FIFO_INPUT_ENTRY];
    iq_entry_t lane [ISSUE_WIDTH];
    logic [BW_PTR-1:0] head_q, head_d, wr_q, wr_d;
    logic [BW_CNT-1:0] count_q, count_d, nin, nout;
    logic [BW_TAG-1:0] tag_q, tag_d;
    logic [ISSUE_WIDTH-1:0] valid;
    logic [BW_PC_MOD-1:0] sel, ub;
    logic [BW_ADDRESS-1:0] pc_base;
    logic flush, push, run;

    assign flush = iq_if.i_branch_valid && iq_if.i_branch_flush;
    assign iq_if.i_pc_ready = !rst && !flush &&
        (BW_CNT'(IQ_DEPTH) - count_q >= BW_CNT'(NUM_FIFO_INPUT_ENTRY));
    assign push = iq_if.i_pc_valid && iq_if.i_pc_ready;
    assign sel = iq_if.i_pc_pc[BW_PC_MOD+1:2];
    assign ub = iq_if.i_pc_pc_upperbound;
    // An upperbound below the first slot still consumes the block, just writes nothing.
    assign nin = (push && ub >= sel) ? BW_CNT'(ub) - BW_CNT'(sel) + BW_CNT'(1) : '0;
    assign pc_base = {iq_if.i_pc_pc[BW_ADDRESS-1:BW_PC_MOD+2], {(BW_PC_MOD+2){1'b0}}};
    assign iq_if.o_count = rst ? '0 : count_q;
    assign iq_if.o_issue_valid = valid;

    always_comb begin
        for (int i = 0; i < NUM_FIFO_INPUT_ENTRY; i++) begin
            slot[i] = '{global_history: iq_if.i_pc_global_history,
                        instruction: iq_if.i_pc_instruction_flatten[i*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA],
                        pc_next: iq_if.i_pc_pc_next_flatten[i*BW_ADDRESS +: BW_ADDRESS],
                        pc: pc_base + BW_ADDRESS'(i * 4)};
        end
    end

    // nout counts only the unbroken run of valid&ready lanes starting at lane 0.
    always_comb begin
        nout = '0;
        run = 1'b1;
        valid = '0;
        iq_if.o_issue_instruction_flatten = '0;
        iq_if.o_issue_pc_flatten = '0;
        iq_if.o_issue_pc_next_flatten = '0;
        iq_if.o_issue_global_history_flatten = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            lane[k] = rst ? '0 : mem_q[head_q + BW_PTR'(k)];
            valid[k] = !rst && !flush && count_q > BW_CNT'(k);
            run = run && valid[k] && iq_if.i_issue_ready[k];
            nout = nout + BW_CNT'(run);
            iq_if.o_issue_instruction_flatten[k*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA] = lane[k].instruction;
            iq_if.o_issue_pc_flatten[k*BW_ADDRESS +: BW_ADDRESS] = lane[k].pc;
            iq_if.o_issue_pc_next_flatten[k*BW_ADDRESS +: BW_ADDRESS] = lane[k].pc_next;
            iq_if.o_issue_global_history_flatten[k*NUM_GLOBAL_HISTORY +: NUM_GLOBAL_HISTORY] = lane[k].global_history;
        end
    end

    iq_tag_rotator #(
        .ISSUE_WIDTH(ISSUE_WIDTH),
        .BW_TAG(BW_TAG),
        .BW_CNT(BW_CNT)
    ) u_tag_rotator (
        .tag_i(tag_q),
        .nout_i(nout),
        .lane_tag_o(iq_if.o_issue_tag_flatten),
        .tag_next_o(tag_d)
    );

    always_comb begin
        head_d = flush ? '0 : head_q + BW_PTR'(nout);
        wr_d = flush ? '0 : wr_q + BW_PTR'(nin);
        count_d = flush ? '0 : count_q + nin - nout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            wr_q <= '0;
            count_q <= '0;
            tag_q <= BW_TAG'(1);
            for (int i = 0; i < IQ_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q <= head_d;
            wr_q <= wr_d;
            count_q <= count_d;
            tag_q <= tag_d;
            for (int i = 0; i < NUM_FIFO_INPUT_ENTRY; i++)
                if (push && BW_PC_MOD'(i) >= sel && BW_PC_MOD'(i) <= ub)
                    mem_q[wr_q + BW_PTR'(BW_PC_MOD'(i) - sel)] <= slot[i];
        end
    end

`ifdef MULTI_ISSUE_IQ_SPECULATION_EN
    logic spec_q, spec_d, acc, hit;
    logic [ISSUE_WIDTH-1:0] spec;

    always_comb begin
        spec = '0;
        acc = spec_q;
        hit = 1'b0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            spec[k] = acc;
            acc = acc || is_control_flow(lane[k].instruction);
            hit = hit || (BW_CNT'(k) < nout && is_control_flow(lane[k].instruction));
        end
        spec_d = (spec_q || hit) && !iq_if.i_branch_valid;
    end

    always_ff @(posedge clk) spec_q <= rst ? 1'b0 : spec_d;

    assign iq_if.o_issue_speculation = spec;
`else
    assign iq_if.o_issue_speculation = '0;
`endif

endmodule

// File: tb/tb_multi_issue_instruction_queue.sv
// tb_multi_issue_instruction_queue: queue-based reference model checked every cycle, plus directed literal checks.
module tb_multi_issue_instruction_queue;

    localparam int BLK = 64, D = 32, A = 32, GH = 4, DEPTH = 8, IW = 2, BT = 2, NFI = 2;
`ifdef MULTI_ISSUE_IQ_SPECULATION_EN
    localparam bit SPEC_EN = 1'b1;
`else
    localparam bit SPEC_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] pcn;
        logic [3:0] gh;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    ent_t q[$];
    int tag_m = 1;
    bit spec_m = 1'b0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multi_issue_instruction_queue_if #(
        .BW_PROCESSOR_BLOCK(BLK), .BW_PROCESSOR_DATA(D), .BW_ADDRESS(A), .NUM_GLOBAL_HISTORY(GH),
        .IQ_DEPTH(DEPTH), .ISSUE_WIDTH(IW), .BW_TAG(BT)
    ) bus ();

    multi_issue_instruction_queue #(
        .BW_PROCESSOR_BLOCK(BLK), .BW_PROCESSOR_DATA(D), .BW_ADDRESS(A), .NUM_GLOBAL_HISTORY(GH),
        .IQ_DEPTH(DEPTH), .ISSUE_WIDTH(IW), .BW_TAG(BT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .iq_if(bus.slave)
    );

    function automatic bit is_cf(logic [31:0] x);
        return x[6:0] == 7'h63 || x[6:0] == 7'h67 || x[6:0] == 7'h6f;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(bit r, bit pv, logic [63:0] ins, logic [31:0] pc, bit ub, logic [3:0] gh,
                        logic [63:0] pcn, bit bv, bit bf, logic [1:0] rdy);
        int n, nout, sel;
        bit flush, rdy_exp, v, sp, cfany;
        @(negedge clk);
        rst = r;
        bus.i_pc_valid = pv;
        bus.i_pc_instruction_flatten = ins;
        bus.i_pc_pc = pc;
        bus.i_pc_pc_upperbound = ub;
        bus.i_pc_global_history = gh;
        bus.i_pc_pc_next_flatten = pcn;
        bus.i_branch_valid = bv;
        bus.i_branch_flush = bf;
        bus.i_issue_ready = rdy;
        #1;
        n = q.size();
        flush = bv && bf;
        rdy_exp = !r && !flush && (DEPTH - n >= NFI);
        chk("pc_ready", bus.i_pc_ready, rdy_exp);
        chk("count", bus.o_count, r ? 0 : n);
        if (r) chk("rst_lane0_instr", bus.o_issue_instruction_flatten[31:0], 0);
        for (int k = 0; k < IW; k++) begin
            v = !r && !flush && n > k;
            chk($sformatf("valid%0d", k), bus.o_issue_valid[k], v);
            if (v) begin
                sp = spec_m;
                for (int j = 0; j < k; j++) sp = sp || is_cf(q[j].ins);
                chk($sformatf("instr%0d", k), bus.o_issue_instruction_flatten[k*32 +: 32], q[k].ins);
                chk($sformatf("pc%0d", k), bus.o_issue_pc_flatten[k*32 +: 32], q[k].pc);
                chk($sformatf("pcn%0d", k), bus.o_issue_pc_next_flatten[k*32 +: 32], q[k].pcn);
                chk($sformatf("gh%0d", k), bus.o_issue_global_history_flatten[k*GH +: GH], q[k].gh);
                chk($sformatf("tag%0d", k), bus.o_issue_tag_flatten[k*BT +: BT], (tag_m - 1 + k) % 3 + 1);
                chk($sformatf("spec%0d", k), bus.o_issue_speculation[k], SPEC_EN && sp);
            end
        end
        if (r || flush) begin
            q.delete();
            spec_m = 1'b0;
            if (r) tag_m = 1;
        end else begin
            nout = 0;
            while (nout < IW && nout < n && rdy[nout]) nout++;
            cfany = 1'b0;
            for (int j = 0; j < nout; j++) cfany = cfany || is_cf(q.pop_front().ins);
            tag_m = (tag_m - 1 + nout) % 3 + 1;
            spec_m = (spec_m || cfany) && !bv;
            if (pv && rdy_exp) begin
                sel = int'(pc[2]);
                for (int i = sel; i <= int'(ub); i++)
                    q.push_back('{ins: ins[i*32 +: 32], pc: {pc[31:3], 3'b000} + 32'(i * 4),
                                  pcn: pcn[i*32 +: 32], gh: gh});
            end
        end
    endtask

    task automatic push_blk(logic [31:0] pc, bit ub, logic [63:0] ins, logic [1:0] rdy);
        step(1'b0, 1'b1, ins, pc, ub, pc[7:4], {pc + 32'h8, pc + 32'h4}, 1'b0, 1'b0, rdy);
    endtask

    task automatic idle(logic [1:0] rdy, bit bv, bit bf);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, bv, bf, rdy);
    endtask

    task automatic peek;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seq [5] = '{3, 1, 2, 3, 1};
        logic [63:0] ins;
        rst = 1'b1;
        bus.i_pc_valid = 1'b0;
        bus.i_pc_instruction_flatten = '0;
        bus.i_pc_pc = '0;
        bus.i_pc_pc_upperbound = '0;
        bus.i_pc_global_history = '0;
        bus.i_pc_pc_next_flatten = '0;
        bus.i_branch_valid = 1'b0;
        bus.i_branch_flush = 1'b0;
        bus.i_issue_ready = '0;
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 2'b00);
        peek();
        chk("lit_rst_count", bus.o_count, 0);
        chk("lit_rst_valid", bus.o_issue_valid, 0);
        chk("lit_rst_ready", bus.i_pc_ready, 0);
        push_blk(32'h4, 1'b1, {32'hAAAA_0013, 32'hBBBB_0013}, 2'b00);
        peek();
        chk("lit_single_count", bus.o_count, 1);
        chk("lit_single_valid", bus.o_issue_valid, 2'b01);
        chk("lit_single_pc", bus.o_issue_pc_flatten[31:0], 32'h4);
        chk("lit_single_instr", bus.o_issue_instruction_flatten[31:0], 32'hAAAA_0013);
        chk("lit_single_tag", bus.o_issue_tag_flatten[1:0], 1);
        push_blk(32'h100, 1'b1, {32'h0000_0113, 32'h0000_0093}, 2'b00);
        push_blk(32'h20C, 1'b1, {32'h0000_0213, 32'h0000_0193}, 2'b00);
        idle(2'b10, 1'b0, 1'b0);
        peek();
        chk("lit_gap_count", bus.o_count, 4);
        chk("lit_gap_tag", bus.o_issue_tag_flatten[1:0], 1);
        idle(2'b11, 1'b0, 1'b0);
        peek();
        chk("lit_dual_count", bus.o_count, 2);
        chk("lit_dual_tag", bus.o_issue_tag_flatten[1:0], 3);
        push_blk(32'h300, 1'b1, {32'h0000_0313, 32'h0000_0293}, 2'b00);
        push_blk(32'h40C, 1'b1, {32'h0000_0413, 32'h0000_0393}, 2'b00);
        peek();
        for (int i = 0; i < 5; i++) begin
            idle(2'b01, 1'b0, 1'b0);
            chk($sformatf("lit_tag_seq%0d", i), bus.o_issue_tag_flatten[1:0], seq[i]);
        end
        peek();
        chk("lit_seq_empty", bus.o_count, 0);
        push_blk(32'h500, 1'b1, {32'h0000_0033, 32'h0000_0063}, 2'b00);
        peek();
        chk("lit_spec_lanes", bus.o_issue_speculation, {SPEC_EN, 1'b0});
        idle(2'b01, 1'b1, 1'b0);
        peek();
        chk("lit_spec_cleared", bus.o_issue_speculation[0], 0);
        chk("lit_spec_count", bus.o_count, 1);
        idle(2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push_blk(32'h600 + 32'(i * 8), 1'b1, {32'h13, 32'h13}, 2'b00);
        push_blk(32'h704, 1'b1, {32'h13, 32'h13}, 2'b00);
        peek();
        chk("lit_full_count", bus.o_count, 7);
        chk("lit_full_ready", bus.i_pc_ready, 0);
        idle(2'b11, 1'b0, 1'b0);
        peek();
        chk("lit_drain_count", bus.o_count, 5);
        chk("lit_drain_ready", bus.i_pc_ready, 1);
        step(1'b0, 1'b1, {32'h13, 32'h13}, 32'h800, 1'b1, 4'h3, '0, 1'b1, 1'b1, 2'b11);
        peek();
        chk("lit_flush_count", bus.o_count, 0);
        chk("lit_flush_tag", bus.o_issue_tag_flatten[1:0], 3);
        chk("lit_flush_valid", bus.o_issue_valid, 0);
        for (int c = 0; c < 3000; c++) begin
            ins = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) ins[6:0] = ($urandom_range(0, 1) == 0) ? 7'h63 : 7'h6f;
            if ($urandom_range(0, 2) == 0) ins[38:32] = 7'h67;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, ins, $urandom,
                 1'($urandom_range(0, 1)), 4'($urandom), {$urandom, $urandom},
                 $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), 2'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
